// File: rtl/write_back_pkg.sv
// Shared definitions for the Y86 write-back stage: status codes, register IDs
// and register-file geometry.
package write_back_pkg;

  localparam int unsigned DATA_WID_DFLT   = 8;
  localparam int unsigned REG_ID_WID_DFLT = 4;
  localparam int unsigned STAT_WID_DFLT   = 4;
  localparam int unsigned CNT_WID_DFLT    = 16;

  localparam int unsigned NUM_REGS    = 8;
  localparam int unsigned REG_IDX_WID = 3;

  // RNONE is the all-ones register ID at the default ID width.
  localparam logic [REG_ID_WID_DFLT-1:0] RNONE = 4'hF;

  typedef enum logic [STAT_WID_DFLT-1:0] {
    STAT_AOK = 4'd1,
    STAT_HLT = 4'd2,
    STAT_ADR = 4'd3,
    STAT_INS = 4'd4
  } stat_e;

endpackage

// File: rtl/write_back_reg_file.sv
// Eight-entry register file with two write ports (valM over valE on a shared
// destination) and two combinational read ports that bypass the pending write.
module write_back_reg_file
  import write_back_pkg::*;
#(
  parameter int unsigned DATA_WID   = DATA_WID_DFLT,
  parameter int unsigned REG_ID_WID = REG_ID_WID_DFLT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [REG_ID_WID-1:0] dst_e,
  input  logic [REG_ID_WID-1:0] dst_m,
  input  logic [DATA_WID-1:0]   val_e,
  input  logic [DATA_WID-1:0]   val_m,
  input  logic [REG_ID_WID-1:0] src_a,
  input  logic [REG_ID_WID-1:0] src_b,
  output logic [DATA_WID-1:0]   rval_a,
  output logic [DATA_WID-1:0]   rval_b
);

  logic [DATA_WID-1:0] regs_q [NUM_REGS];
  logic [DATA_WID-1:0] regs_d [NUM_REGS];

  // IDs at or above NUM_REGS (including RNONE) address no storage.
  function automatic logic is_reg(input logic [REG_ID_WID-1:0] id);
    return id < REG_ID_WID'(NUM_REGS);
  endfunction

  function automatic logic [DATA_WID-1:0] read_port(
    input logic [REG_ID_WID-1:0] src,
    input logic [DATA_WID-1:0]   stored
  );
    logic [DATA_WID-1:0] val;
    val = '0;
    if (is_reg(src)) begin
      if (we && dst_m == src)      val = val_m;
      else if (we && dst_e == src) val = val_e;
      else                         val = stored;
    end
    return val;
  endfunction

  // The valM write is applied last so it wins on dst_e == dst_m.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
    if (we && is_reg(dst_e)) regs_d[dst_e[REG_IDX_WID-1:0]] = val_e;
    if (we && is_reg(dst_m)) regs_d[dst_m[REG_IDX_WID-1:0]] = val_m;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    rval_a = read_port(src_a, regs_q[src_a[REG_IDX_WID-1:0]]);
    rval_b = read_port(src_b, regs_q[src_b[REG_IDX_WID-1:0]]);
  end

endmodule

// File: rtl/write_back.sv
// Y86 write-back stage: M/W pipeline register, commit to the register file,
// first-fault status latch with commit halt, and retired-instruction counter.
module write_back
  import write_back_pkg::*;
#(
  parameter int unsigned DATA_WID   = DATA_WID_DFLT,
  parameter int unsigned REG_ID_WID = REG_ID_WID_DFLT,
  parameter int unsigned STAT_WID   = STAT_WID_DFLT,
  parameter int unsigned CNT_WID    = CNT_WID_DFLT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m_valid,
  input  logic [STAT_WID-1:0]   m_stat,
  input  logic [STAT_WID-1:0]   m_icode,
  input  logic [DATA_WID-1:0]   m_valE,
  input  logic [DATA_WID-1:0]   m_valM,
  input  logic [REG_ID_WID-1:0] m_dstE,
  input  logic [REG_ID_WID-1:0] m_dstM,
  input  logic [REG_ID_WID-1:0] srcA,
  input  logic [REG_ID_WID-1:0] srcB,
  output logic [DATA_WID-1:0]   rvalA,
  output logic [DATA_WID-1:0]   rvalB,
  output logic [STAT_WID-1:0]   w_icode,
  output logic [STAT_WID-1:0]   cpu_stat,
  output logic                  halted,
  output logic [CNT_WID-1:0]    retired
);

  localparam logic [STAT_WID-1:0]   AOK_CODE = STAT_WID'(STAT_AOK);
  localparam logic [REG_ID_WID-1:0] RNONE_ID = '1;

  logic                  w_valid_q,  w_valid_d;
  logic [STAT_WID-1:0]   w_stat_q,   w_stat_d;
  logic [STAT_WID-1:0]   w_icode_q,  w_icode_d;
  logic [DATA_WID-1:0]   w_val_e_q,  w_val_e_d;
  logic [DATA_WID-1:0]   w_val_m_q,  w_val_m_d;
  logic [REG_ID_WID-1:0] w_dst_e_q,  w_dst_e_d;
  logic [REG_ID_WID-1:0] w_dst_m_q,  w_dst_m_d;
  logic [STAT_WID-1:0]   cpu_stat_q, cpu_stat_d;
  logic                  halted_q,   halted_d;
  logic [CNT_WID-1:0]    retired_q,  retired_d;

  logic halt_set_c;
  logic w_we_c;

  assign halt_set_c = w_valid_q && (w_stat_q != AOK_CODE);
  assign w_we_c     = w_valid_q && (w_stat_q == AOK_CODE);

  // Next-state: W capture, halt latch, saturating retire count.
  always_comb begin
    w_valid_d  = 1'b0;
    w_stat_d   = w_stat_q;
    w_icode_d  = w_icode_q;
    w_val_e_d  = w_val_e_q;
    w_val_m_d  = w_val_m_q;
    w_dst_e_d  = w_dst_e_q;
    w_dst_m_d  = w_dst_m_q;
    cpu_stat_d = cpu_stat_q;
    halted_d   = halted_q;
    retired_d  = retired_q;

    if (!halted_q && !halt_set_c) begin
      w_valid_d = m_valid;
      w_stat_d  = m_stat;
      w_icode_d = m_icode;
      w_val_e_d = m_valE;
      w_val_m_d = m_valM;
      w_dst_e_d = m_dstE;
      w_dst_m_d = m_dstM;
    end

    if (halt_set_c) begin
      cpu_stat_d = w_stat_q;
      halted_d   = 1'b1;
    end

    if (w_we_c && (retired_q != '1)) begin
      retired_d = retired_q + CNT_WID'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid_q  <= 1'b0;
      w_stat_q   <= AOK_CODE;
      w_icode_q  <= '0;
      w_val_e_q  <= '0;
      w_val_m_q  <= '0;
      w_dst_e_q  <= RNONE_ID;
      w_dst_m_q  <= RNONE_ID;
      cpu_stat_q <= AOK_CODE;
      halted_q   <= 1'b0;
      retired_q  <= '0;
    end else begin
      w_valid_q  <= w_valid_d;
      w_stat_q   <= w_stat_d;
      w_icode_q  <= w_icode_d;
      w_val_e_q  <= w_val_e_d;
      w_val_m_q  <= w_val_m_d;
      w_dst_e_q  <= w_dst_e_d;
      w_dst_m_q  <= w_dst_m_d;
      cpu_stat_q <= cpu_stat_d;
      halted_q   <= halted_d;
      retired_q  <= retired_d;
    end
  end

  write_back_reg_file #(
    .DATA_WID   (DATA_WID),
    .REG_ID_WID (REG_ID_WID)
  ) u_reg_file (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (w_we_c),
    .dst_e  (w_dst_e_q),
    .dst_m  (w_dst_m_q),
    .val_e  (w_val_e_q),
    .val_m  (w_val_m_q),
    .src_a  (srcA),
    .src_b  (srcB),
    .rval_a (rvalA),
    .rval_b (rvalB)
  );

  assign w_icode  = w_icode_q;
  assign cpu_stat = cpu_stat_q;
  assign halted   = halted_q;
  assign retired  = retired_q;

endmodule
